// File: rtl/sprite_pkg.sv
// Shared sprite definitions used by the display path and the image loader.
package sprite_pkg;

   // Default sprite geometry and palette index width.
   localparam int SPRITE_WIDTH      = 256;
   localparam int SPRITE_HEIGHT     = 256;
   localparam int SPRITE_DATA_WIDTH = 8;

   // Loader control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } loader_state_t;

   // Counter width that never collapses to zero bits for a dimension of 1.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/image_sprite_loader.sv
// Stream-to-BRAM sprite loader: writes a raster-order palette-index stream
// into port A of the dual-port image BRAM, one write per accepted pixel.
module image_sprite_loader
   import sprite_pkg::*;
#(
   parameter  int WIDTH      = SPRITE_WIDTH,
   parameter  int HEIGHT     = SPRITE_HEIGHT,
   parameter  int DATA_WIDTH = SPRITE_DATA_WIDTH,
   localparam int ADDR_WIDTH = $clog2(WIDTH*HEIGHT)
)(
   input  logic                  pixel_clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic                  pixel_valid_in,
   input  logic [DATA_WIDTH-1:0] pixel_data_in,
   input  logic                  pixel_last_in,
   output logic                  pixel_ready_out,
   output logic [ADDR_WIDTH-1:0] bram_addr_out,
   output logic [DATA_WIDTH-1:0] bram_data_out,
   output logic                  bram_we_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  error_out
);

   localparam int X_W = clog2_min1(WIDTH);
   localparam int Y_W = clog2_min1(HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH*HEIGHT-1);
   localparam logic [X_W-1:0]        LAST_X    = X_W'(WIDTH-1);

   loader_state_t r_state, w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_addr_cnt;
   logic [X_W-1:0]        r_x_cnt;
   logic [Y_W-1:0]        r_y_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_we;
   logic                  r_done;
   logic                  r_error;

   logic w_ready;
   logic w_hs;
   logic w_at_end;
   logic w_term;
   logic w_start;

   assign w_ready  = (r_state == LOAD);
   assign w_hs     = pixel_valid_in & w_ready;
   assign w_at_end = (r_addr_cnt == LAST_ADDR);
   // Frame ends on whichever comes first: geometric end or upstream last.
   assign w_term   = w_hs & (w_at_end | pixel_last_in);
   assign w_start  = (r_state == IDLE) & start_in;

   // State register.
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; FLUSH is a single cycle carrying the final write.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_in) w_state_nxt = LOAD;
         LOAD:    if (w_term)   w_state_nxt = FLUSH;
         FLUSH:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Raster counters, registered write port, done pulse and sticky error.
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         r_addr_cnt <= '0;
         r_x_cnt    <= '0;
         r_y_cnt    <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_we   <= w_hs;
         r_done <= (r_state == FLUSH);
         if (w_start) begin
            r_addr_cnt <= '0;
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_error    <= 1'b0;
         end else if (w_hs) begin
            // Address and data hold between handshakes; only the strobe drops.
            r_addr     <= r_addr_cnt;
            r_data     <= pixel_data_in;
            r_addr_cnt <= r_addr_cnt + 1'b1;
            if (r_x_cnt == LAST_X) begin
               r_x_cnt <= '0;
               r_y_cnt <= r_y_cnt + 1'b1;
            end else begin
               r_x_cnt <= r_x_cnt + 1'b1;
            end
            // Early last, or no last on the final pixel, is a length mismatch.
            if (w_term && (w_at_end != pixel_last_in)) r_error <= 1'b1;
         end
      end
   end

   // While loading, the linear address must track the x/y raster position.
   assert property (@(posedge pixel_clk_in) disable iff (rst_in)
      (r_state == LOAD) |-> (int'(r_addr_cnt) == int'(r_y_cnt)*WIDTH + int'(r_x_cnt)));

   assign pixel_ready_out = w_ready;
   assign busy_out        = (r_state != IDLE);
   assign bram_addr_out   = r_addr;
   assign bram_data_out   = r_data;
   assign bram_we_out     = r_we;
   assign done_out        = r_done;
   assign error_out       = r_error;

endmodule
